// File: rtl/display_scheduler_if.sv
// Bus between the control logic (master) and the display scheduler (slave).
// Carries the live value, the per-requester level requests with their values,
// and the scheduler's registered ack/entry/busy/owner outputs.
//
// Handshake: req[i] is a level request. It counts as valid in a cycle only
// when req[i]==1 and ack[i]==0. ack[i] is a one-cycle registered grant pulse.
// A requester drops req[i] the cycle after it samples ack[i]. If req[i] is
// still high after that cycle, the scheduler treats it as a new request.
// dbg_hold exposes the scheduler FSM state (1 = HOLD, 0 = IDLE).
interface display_scheduler_if #(
    parameter int NREQ = 3
);
    logic [10:0]        live_value;
    logic [NREQ-1:0]    req;
    logic [NREQ*11-1:0] req_value;
    logic [NREQ-1:0]    ack;
    logic [10:0]        entry;
    logic               busy;
    logic [1:0]         owner;
    logic               dbg_hold;

    modport master (
        output live_value, req, req_value,
        input  ack, entry, busy, owner, dbg_hold
    );

    modport slave (
        input  live_value, req, req_value,
        output ack, entry, busy, owner, dbg_hold
    );
endinterface

// File: rtl/display_scheduler.sv
// display_scheduler: shares the 4-digit display between a live value and NREQ
// temporary requesters. A granted requester's value is held for HOLD_CYCLES
// clocks, and then the display reverts to the live value. When the hold
// expires, a waiting requester is granted directly, with no idle gap.
// Optional feature macro: ROUND_ROBIN_EN. When it is defined, priority rotates
// from the last winner. When it is not defined, priority is fixed and the
// lowest index wins.
module display_scheduler #(
    parameter int NREQ        = 3,
    parameter int HOLD_CYCLES = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic           clock,
    input  logic           reset,
    display_scheduler_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [10:0]       entry_q, entry_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              busy_q, busy_d;
    logic [1:0]        owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef ROUND_ROBIN_EN
    logic [1:0]        rr_q, rr_d;
    logic [1:0]        rr_idx;
    logic              rr_found;
`endif

    logic [NREQ-1:0]   valid;
    logic [NREQ-1:0]   owner_oh;
    logic [NREQ-1:0]   cand;
    logic              expired;
    logic              refresh;
    logic              grant;
    logic [1:0]        win;

    // Classify this cycle's requests: valid, owner refresh, expiry, and grant candidates
    always_comb begin
        valid    = bus.req & ~ack_q;
        owner_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == 2'(i + 1)) owner_oh[i] = 1'b1;
        end
        expired = (state_q == HOLD) && (cnt_q == '0);
        refresh = (state_q == HOLD) && (|(valid & owner_oh));
        if (state_q == IDLE) begin
            cand = valid;
        end else if (expired) begin
            cand = valid & ~owner_oh;
        end else begin
            cand = '0;
        end
        grant = !refresh && (|cand);
    end

    // Choose the winner among the candidates
    always_comb begin
        win = '0;
`ifdef ROUND_ROBIN_EN
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx = 2'((int'(rr_q) + 1 + k) % NREQ);
            if (!rr_found && cand[rr_idx]) begin
                win      = rr_idx;
                rr_found = 1'b1;
            end
        end
`else
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand[i]) win = 2'(i);
        end
`endif
    end

    // State register and all output/datapath flops, with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            entry_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            cnt_q   <= '0;
`ifdef ROUND_ROBIN_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
`ifdef ROUND_ROBIN_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // Next state: enter HOLD on a grant; leave HOLD only on an expiry with nothing to grant
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = HOLD;
            HOLD:    if (expired && !refresh && !grant) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: refresh beats a new grant, a running hold counts down, otherwise show the live value
    always_comb begin
        entry_d = entry_q;
        ack_d   = '0;
        busy_d  = busy_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
`ifdef ROUND_ROBIN_EN
        rr_d    = rr_q;
`endif
        if (refresh) begin
            for (int i = 0; i < NREQ; i++) begin
                if (owner_oh[i]) entry_d = bus.req_value[11*i +: 11];
            end
            ack_d = owner_oh;
            cnt_d = CNT_RELOAD;
`ifdef ROUND_ROBIN_EN
            rr_d  = owner_q - 2'd1;
`endif
        end else if (grant) begin
            for (int i = 0; i < NREQ; i++) begin
                if (win == 2'(i)) begin
                    entry_d  = bus.req_value[11*i +: 11];
                    ack_d[i] = 1'b1;
                end
            end
            owner_d = win + 2'd1;
            busy_d  = 1'b1;
            cnt_d   = CNT_RELOAD;
`ifdef ROUND_ROBIN_EN
            rr_d    = win;
`endif
        end else if ((state_q == HOLD) && !expired) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            entry_d = bus.live_value;
            busy_d  = 1'b0;
            owner_d = '0;
        end
    end

    assign bus.entry    = entry_q;
    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;
    assign bus.dbg_hold = (state_q == HOLD);

endmodule
